uart_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares one UART serializer (the `piso_reg` parallel-in/serial-out stage) among `NUM_REQ` byte requesters. It arbitrates pending requests, computes the parity bit, and sequences the serializer's `load`/`shift` strobes to produce one 11-bit frame per granted byte: start, 8 data LSB-first, parity, stop. It sits between the host-side transmit queues and the serializer and runs on the serializer's bit-rate clock, one `reg_clk` cycle per bit.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// The GUARD state exists only when UART_TX_GUARD_EN is defined.
package uart_pkg;

`ifdef UART_TX_GUARD_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GUARD} tx_sched_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} tx_sched_state_t;
`endif

    // Data bits, parity and stop are shifted; the start bit comes from the load.
    localparam int FRAME_SHIFTS = 10;

    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first pending request at or after ptr,
// returned one-hot and as an encoded index.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART serializer among NUM_REQ requesters.
// Define UART_TX_GUARD_EN to insert GUARD_BITS idle bit times after each stop bit.
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int GUARD_BITS = 1
) (
    input  logic                         reg_clk,
    input  logic                         reg_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         parity_odd,
    output logic                         load,
    output logic                         shift,
    output logic                         parity_bit,
    output logic [7:0]                   p_data_in,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         tx_done
);
    import uart_pkg::*;

    localparam int         IDX_W     = $clog2(NUM_REQ);
    localparam logic [3:0] LAST_BIT  = 4'(FRAME_SHIFTS - 1);
    localparam logic [3:0] PRE_LAST  = 4'(FRAME_SHIFTS - 2);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("uart_tx_sched: NUM_REQ must be 2..16");
    end
    if (GUARD_BITS < 1 || GUARD_BITS > 15) begin : g_bad_guard_bits
        $error("uart_tx_sched: GUARD_BITS must be 1..15");
    end

    tx_sched_state_t    state;
    logic [IDX_W-1:0]   ptr;
    logic [3:0]         bit_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               arb_now;
    logic [7:0]         sel_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign sel_data = req_data[{arb_idx, 3'b000} +: 8];

`ifdef UART_TX_GUARD_EN
    localparam logic [3:0] LAST_GUARD = 4'(GUARD_BITS - 1);
    logic [3:0] guard_cnt;
    assign arb_now = (state == ST_IDLE) || (state == ST_GUARD && guard_cnt == LAST_GUARD);
`else
    // Without the guard the next frame is chosen during the stop-bit shift.
    assign arb_now = (state == ST_IDLE) || (state == ST_SHIFT && bit_cnt == LAST_BIT);
`endif

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            bit_cnt    <= '0;
            load       <= 1'b0;
            shift      <= 1'b0;
            req_ready  <= '0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            grant_id   <= '0;
            p_data_in  <= '0;
            parity_bit <= 1'b0;
`ifdef UART_TX_GUARD_EN
            guard_cnt  <= '0;
`endif
        end else begin
            load      <= 1'b0;
            shift     <= 1'b0;
            req_ready <= '0;
            tx_done   <= 1'b0;
            if (arb_now) begin
                bit_cnt <= '0;
                if (arb_any) begin
                    state      <= ST_LOAD;
                    load       <= 1'b1;
                    busy       <= 1'b1;
                    req_ready  <= arb_gnt;
                    grant_id   <= arb_idx;
                    p_data_in  <= sel_data;
                    parity_bit <= calc_parity(sel_data, parity_odd);
                    ptr        <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                end else begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_LOAD: begin
                        state   <= ST_SHIFT;
                        shift   <= 1'b1;
                        bit_cnt <= '0;
                    end
                    ST_SHIFT: begin
                        if (bit_cnt != LAST_BIT) begin
                            shift   <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_done <= (bit_cnt == PRE_LAST);
                        end
`ifdef UART_TX_GUARD_EN
                        else begin
                            state     <= ST_GUARD;
                            guard_cnt <= '0;
                        end
`endif
                    end
`ifdef UART_TX_GUARD_EN
                    ST_GUARD: guard_cnt <= guard_cnt + 1'b1;
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: vector table, directed corner sequences and a
// randomized run checked cycle by cycle against a frame-level timing model.
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef UART_TX_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif
    localparam int FRAME = 11 + G;

    logic          reg_clk = 1'b0;
    logic          reg_rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic          parity_odd = 1'b0;
    logic [N-1:0]  req_ready;
    logic          load, shift, parity_bit, busy, tx_done;
    logic [7:0]    p_data_in;
    logic [IW-1:0] grant_id;

    uart_tx_sched #(.NUM_REQ(N), .GUARD_BITS(2)) dut (
        .reg_clk    (reg_clk),
        .reg_rst    (reg_rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .parity_odd (parity_odd),
        .load       (load),
        .shift      (shift),
        .parity_bit (parity_bit),
        .p_data_in  (p_data_in),
        .busy       (busy),
        .grant_id   (grant_id),
        .tx_done    (tx_done)
    );

    always #5 reg_clk = ~reg_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural serializer: start bit on load, then one bit per shift.
    logic       line = 1'b1;
    logic [9:0] sreg = '1;
    always @(posedge reg_clk) begin
        if (load) begin
            line <= 1'b0;
            sreg <= {1'b1, parity_bit, p_data_in};
        end else if (shift) begin
            line <= sreg[0];
            sreg <= {1'b1, sreg[9:1]};
        end else begin
            line <= 1'b1;
        end
    end

    // Reference model: inputs seen at each edge, frame timing by arithmetic.
    logic           prev_rst = 1'b1;
    logic [N-1:0]   prev_valid = '0;
    logic [8*N-1:0] prev_data = '0;
    logic           prev_odd = 1'b0;

    always @(posedge reg_clk) begin
        prev_rst   = reg_rst;
        prev_valid = req_valid;
        prev_data  = req_data;
        prev_odd   = parity_odd;
    end

    int            cyc = 0;
    int            last_load = -1000;
    int            ptr_m = 0;
    int            g;
    logic          m_arb, m_ld, m_sh, m_dn, m_bz, m_par;
    logic [N-1:0]  m_rdy;
    logic [7:0]    m_data = '0;
    logic [IW-1:0] m_gid = '0;

    always @(negedge reg_clk) begin
        cyc++;
        m_rdy = '0;
        m_ld  = 1'b0;
        m_arb = 1'b0;
        if (prev_rst) begin
            last_load = -1000;
            ptr_m     = 0;
            m_data    = '0;
            m_par     = 1'b0;
            m_gid     = '0;
        end else begin
            m_arb = (cyc - 1 >= last_load + 10 + G);
            if (m_arb && prev_valid != '0) begin
                g = -1;
                for (int i = 0; i < N; i++)
                    if (g < 0 && prev_valid[(ptr_m + i) % N]) g = (ptr_m + i) % N;
                m_ld      = 1'b1;
                m_rdy[g]  = 1'b1;
                m_data    = prev_data[8*g +: 8];
                m_par     = (^m_data) ^ prev_odd;
                m_gid     = IW'(g);
                ptr_m     = (g + 1) % N;
                last_load = cyc;
            end
        end
        m_sh = !prev_rst && (cyc >= last_load + 1) && (cyc <= last_load + 10);
        m_dn = !prev_rst && (cyc == last_load + 10);
        m_bz = !prev_rst && !(m_arb && !m_ld);
        check("outputs", {req_ready, load, shift, tx_done, busy, grant_id, p_data_in, parity_bit},
                         {m_rdy, m_ld, m_sh, m_dn, m_bz, m_gid, m_data, m_par});
        check("load_shift_excl", {31'd0, load & shift}, 32'd0);
    end

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge reg_clk);
            if (load) ok = 1'b1;
        end
        check("load_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge reg_clk);
            if (!busy) ok = 1'b1;
        end
        check("idle_seen", {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       odd;
        logic [3:0] rdy;
        logic       par;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          sh_cnt, done_at;
        int          gids[5];
        longint      tl[5];
        int          exp_line[11];
        int          exp_gid[5];
        bit          saw3;

        tbl[0] = '{2, 8'hA5, 1'b0, 4'b0100, 1'b0};
        tbl[1] = '{1, 8'h03, 1'b1, 4'b0010, 1'b1};
        tbl[2] = '{3, 8'h07, 1'b1, 4'b1000, 1'b0};
        tbl[3] = '{0, 8'hFF, 1'b0, 4'b0001, 1'b0};
        tbl[4] = '{0, 8'h01, 1'b1, 4'b0001, 1'b0};
        tbl[5] = '{3, 8'h00, 1'b1, 4'b1000, 1'b1};
        tbl[6] = '{1, 8'h80, 1'b0, 4'b0010, 1'b1};
        exp_line = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        exp_gid  = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge reg_clk);
        reg_rst = 1'b0;
        @(negedge reg_clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_outputs", {req_ready, load, shift, tx_done, grant_id, p_data_in, parity_bit}, '0);

        // Single byte with serializer line check.
        req_data[23:16] = 8'hA5;
        parity_odd      = 1'b0;
        req_valid       = 4'b0100;
        wait_load(ok);
        check("single_ready", {28'd0, req_ready}, 32'h4);
        check("single_data", {24'd0, p_data_in}, 32'hA5);
        check("single_parity", {31'd0, parity_bit}, 32'd0);
        sh_cnt  = 0;
        done_at = -1;
        for (int i = 0; i < 11; i++) begin
            @(negedge reg_clk);
            req_valid = '0;
            check("single_line", {31'd0, line}, exp_line[i]);
            if (shift) sh_cnt++;
            if (tx_done && done_at < 0) done_at = i;
        end
        check("single_shift_count", sh_cnt, 10);
        check("single_done_pos", done_at, 9);

        // Vector table.
        for (int v = 0; v < 7; v++) begin
            wait_idle();
            req_data[8*tbl[v].k +: 8] = tbl[v].d;
            parity_odd = tbl[v].odd;
            req_valid[tbl[v].k] = 1'b1;
            wait_load(ok);
            check("tbl_ready", {28'd0, req_ready}, {28'd0, tbl[v].rdy});
            check("tbl_data", {24'd0, p_data_in}, {24'd0, tbl[v].d});
            check("tbl_parity", {31'd0, parity_bit}, {31'd0, tbl[v].par});
            check("tbl_gid", {30'd0, grant_id}, tbl[v].k);
            req_valid = '0;
            done_at = -1;
            for (int i = 1; i <= 12; i++) begin
                @(negedge reg_clk);
                if (tx_done && done_at < 0) done_at = i;
            end
            check("tbl_done_pos", done_at, 10);
        end

        // Fairness: all requesters valid from reset.
        wait_idle();
        reg_rst   = 1'b1;
        req_valid = '1;
        for (int k = 0; k < N; k++) req_data[8*k +: 8] = 8'($urandom);
        repeat (2) @(negedge reg_clk);
        reg_rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            wait_load(ok);
            gids[n] = int'(grant_id);
            tl[n]   = $time;
            if (n < 4) req_data[8*grant_id +: 8] = 8'($urandom);
        end
        req_valid = '0;
        for (int n = 0; n < 5; n++) check("fair_order", gids[n], exp_gid[n]);
        for (int n = 1; n < 5; n++) check("fair_spacing", int'((tl[n] - tl[n-1]) / 10), FRAME);

        // Reset in the middle of a frame owned by requester 2.
        wait_idle();
        req_valid = 4'b0100;
        wait_load(ok);
        req_valid = '0;
        repeat (5) @(negedge reg_clk);
        check("midrst_shifting", {31'd0, shift}, 32'd1);
        reg_rst = 1'b1;
        @(negedge reg_clk);
        check("midrst_strobes", {30'd0, load, shift}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        reg_rst   = 1'b0;
        req_valid = 4'b1010;
        wait_load(ok);
        check("midrst_gid", {30'd0, grant_id}, 32'd1);
        check("midrst_ready", {28'd0, req_ready}, 32'h2);
        req_valid = '0;

        // Requester 3 pulses valid during another frame, then withdraws.
        wait_idle();
        req_data[7:0] = 8'h5A;
        req_valid     = 4'b0001;
        wait_load(ok);
        repeat (2) @(negedge reg_clk);
        req_valid = 4'b1000;
        repeat (2) @(negedge reg_clk);
        req_valid = '0;
        saw3 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge reg_clk);
            if (req_ready[3]) saw3 = 1'b1;
        end
        check("drop_no_ready3", {31'd0, saw3}, 32'd0);
        check("drop_busy", {31'd0, busy}, 32'd0);

        // Randomized traffic with occasional resets and withdrawn requests.
        for (int c = 0; c < 4000; c++) begin
            @(posedge reg_clk);
            #1;
            reg_rst    = ($urandom_range(0, 599) == 0);
            parity_odd = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) begin
                if (req_ready[k]) begin
                    req_valid[k] = 1'($urandom_range(0, 1));
                    req_data[8*k +: 8] = 8'($urandom);
                end else if (!req_valid[k]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        req_valid[k] = 1'b1;
                        req_data[8*k +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
        end
        reg_rst   = 1'b0;
        req_valid = '0;
        repeat (30) @(negedge reg_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
